master_port: RTL and testbench

- Initiator side of the serial system bus: accepts a parallel read/write request from a local device and serializes the address and write data onto the bus.
- For reads, deserializes the returned data.
- Drives the mode/valid/data wires that a slave port receives, and consumes that slave's ready/valid/read-data wires.
- Sits between a master device (CPU/test driver) and the bus interconnect.

---
 rtl/master_port.sv | 185 ++++++++++++++++++
 tb/tb_master_port.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/master_port.sv
// Initiator side of the serial system bus: serializes address/write data LSB first and
// deserializes read data. Define MPORT_TIMEOUT_EN to enable the WAIT_READY/RDATA watchdog.
module master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dreq,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic                  dready,
    output logic                  ddone,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  derr,
    output logic                  mwdata,
    input  logic                  mrdata,
    output logic                  mmode,
    output logic                  mvalid,
    input  logic                  svalid,
    input  logic                  sready
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW) + 1;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        StIdle, StWaitReady, StAddr, StWdata, StRdata, StDone
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         bitcnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  mode_q;

`ifdef MPORT_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wdog_q;
    logic           derr_q;
    assign derr = derr_q;
`else
    assign derr = 1'b0;
`endif

    // Address and write data are shifted out of bit 0; read data shifts in at the MSB.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            bitcnt_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mode_q   <= 1'b0;
            dready   <= 1'b1;
            ddone    <= 1'b0;
            drdata   <= '0;
            mwdata   <= 1'b0;
            mmode    <= 1'b0;
            mvalid   <= 1'b0;
`ifdef MPORT_TIMEOUT_EN
            wdog_q   <= '0;
            derr_q   <= 1'b0;
`endif
        end else begin
            ddone <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (dreq) begin
                        addr_q  <= daddr;
                        wdata_q <= dwdata;
                        mode_q  <= dmode;
                        dready  <= 1'b0;
                        state_q <= StWaitReady;
`ifdef MPORT_TIMEOUT_EN
                        wdog_q  <= '0;
`endif
                    end
                end
                StWaitReady: begin
                    if (sready) begin
                        state_q  <= StAddr;
                        bitcnt_q <= '0;
                        mvalid   <= 1'b1;
                        mmode    <= mode_q;
                        mwdata   <= addr_q[0];
                        addr_q   <= addr_q >> 1;
                    end
`ifdef MPORT_TIMEOUT_EN
                    else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                        state_q <= StDone;
                        ddone   <= 1'b1;
                        derr_q  <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
`endif
                end
                StAddr: begin
                    if (bitcnt_q == CW'(ADDR_WIDTH - 1)) begin
                        bitcnt_q <= '0;
                        if (mode_q) begin
                            state_q <= StWdata;
                            mmode   <= 1'b1;
                            mwdata  <= wdata_q[0];
                            wdata_q <= wdata_q >> 1;
                        end else begin
                            state_q <= StRdata;
                            mvalid  <= 1'b0;
                            mwdata  <= 1'b0;
                            mmode   <= 1'b0;
`ifdef MPORT_TIMEOUT_EN
                            wdog_q  <= '0;
`endif
                        end
                    end else begin
                        bitcnt_q <= bitcnt_q + 1'b1;
                        mwdata   <= addr_q[0];
                        addr_q   <= addr_q >> 1;
                    end
                end
                StWdata: begin
                    if (bitcnt_q == CW'(DATA_WIDTH - 1)) begin
                        bitcnt_q <= '0;
                        state_q  <= StDone;
                        ddone    <= 1'b1;
                        mvalid   <= 1'b0;
                        mwdata   <= 1'b0;
                        mmode    <= 1'b0;
`ifdef MPORT_TIMEOUT_EN
                        derr_q   <= 1'b0;
`endif
                    end else begin
                        bitcnt_q <= bitcnt_q + 1'b1;
                        mwdata   <= wdata_q[0];
                        wdata_q  <= wdata_q >> 1;
                    end
                end
                StRdata: begin
                    if (svalid) begin
                        rdata_q <= {mrdata, rdata_q[DATA_WIDTH-1:1]};
`ifdef MPORT_TIMEOUT_EN
                        wdog_q  <= '0;
`endif
                        if (bitcnt_q == CW'(DATA_WIDTH - 1)) begin
                            bitcnt_q <= '0;
                            state_q  <= StDone;
                            ddone    <= 1'b1;
                            drdata   <= {mrdata, rdata_q[DATA_WIDTH-1:1]};
`ifdef MPORT_TIMEOUT_EN
                            derr_q   <= 1'b0;
`endif
                        end else begin
                            bitcnt_q <= bitcnt_q + 1'b1;
                        end
                    end
`ifdef MPORT_TIMEOUT_EN
                    else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                        bitcnt_q <= '0;
                        state_q  <= StDone;
                        ddone    <= 1'b1;
                        drdata   <= '0;
                        derr_q   <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
`endif
                end
                StDone: begin
                    state_q <= StIdle;
                    dready  <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_master_port.sv
// Scoreboard bench for master_port: stimulus queues expected bus bits and completions,
// a negedge monitor pops and compares them as the DUT presents mvalid / ddone.
module tb_master_port;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          dreq = 1'b0;
    logic          dmode = 1'b0;
    logic [AW-1:0] daddr = '0;
    logic [DW-1:0] dwdata = '0;
    logic          dready, ddone, derr, mwdata, mmode, mvalid;
    logic [DW-1:0] drdata;
    logic          mrdata = 1'b0;
    logic          svalid = 1'b0;
    logic          sready = 1'b0;

    master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(64)) dut (
        .clk(clk), .rstn(rstn), .dreq(dreq), .dmode(dmode), .daddr(daddr), .dwdata(dwdata),
        .dready(dready), .ddone(ddone), .drdata(drdata), .derr(derr), .mwdata(mwdata),
        .mrdata(mrdata), .mmode(mmode), .mvalid(mvalid), .svalid(svalid), .sready(sready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          mode;
        logic [DW-1:0] rdata;
        logic          err;
    } resp_t;

    int    n_vec = 0, n_bad = 0;
    int    cyc = 0, cap = 0, done_cnt = 0, done_cyc = 0, run = 0, last_run = 0;
    resp_t resp_q[$];
    logic [1:0] bit_q[$];
    logic [1:0] mon_bit;
    resp_t      mon_resp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mvalid) begin
            run++;
            if (bit_q.size() == 0) chk("mvalid_spurious", 1, 0);
            else begin
                mon_bit = bit_q.pop_front();
                chk("mmode", mmode, mon_bit[1]);
                chk("mwdata", mwdata, mon_bit[0]);
            end
        end else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        if (ddone) begin
            done_cnt++;
            done_cyc = cyc;
            if (resp_q.size() == 0) chk("ddone_spurious", 1, 0);
            else begin
                mon_resp = resp_q.pop_front();
                chk("derr", derr, mon_resp.err);
                if (!mon_resp.mode) chk("drdata", drdata, mon_resp.rdata);
            end
        end
    end

    task automatic do_req(input logic mode, input logic [AW-1:0] a, input logic [DW-1:0] w,
                          input resp_t r);
        int k = 0;
        @(negedge clk);
        while (!dready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!dready) chk("dready_timeout", 0, 1);
        for (int i = 0; i < AW; i++) bit_q.push_back({mode, a[i]});
        if (mode) for (int i = 0; i < DW; i++) bit_q.push_back({1'b1, w[i]});
        resp_q.push_back(r);
        dreq = 1'b1; dmode = mode; daddr = a; dwdata = w;
        @(posedge clk);
        #1;
        cap = cyc;
        dreq = 1'b0; dmode = ~mode; daddr = ~a; dwdata = ~w;
    endtask

    task automatic wait_done(input int start, output int lat);
        int k = 0;
        while (done_cnt == start && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == start) begin
            chk("ddone_timeout", 0, 1);
            lat = -1;
        end else lat = done_cyc - cap;
    endtask

    task automatic wait_addr_end();
        int  k = 0;
        bit  seen = 0;
        bit  ended = 0;
        while (!ended && k < 100) begin
            @(negedge clk);
            k++;
            if (mvalid) seen = 1;
            else if (seen) ended = 1;
        end
        if (!ended) chk("addr_end_timeout", 0, 1);
    endtask

    task automatic slave_send(input logic [DW-1:0] d, input int delay, input int gap_at,
                              input int gap_len);
        repeat (delay) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            svalid = 1'b1;
            mrdata = d[i];
            @(negedge clk);
            if (i == gap_at) begin
                svalid = 1'b0;
                mrdata = 1'b1;
                repeat (gap_len) @(negedge clk);
            end
        end
        svalid = 1'b0;
        mrdata = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int s, lat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dready", dready, 1);
        chk("rst_ddone", ddone, 0);
        chk("rst_derr", derr, 0);
        chk("rst_drdata", drdata, 0);
        chk("rst_mvalid", mvalid, 0);
        chk("rst_mmode", mmode, 0);
        chk("rst_mwdata", mwdata, 0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Write; svalid toggling outside RDATA must be ignored.
        sready = 1'b1; svalid = 1'b1; mrdata = 1'b1;
        s = done_cnt;
        do_req(1'b1, 12'hA5C, 8'h3C, resp_t'{1'b1, 8'h00, 1'b0});
        wait_done(s, lat);
        chk("wr_latency", lat, 21);
        @(negedge clk);
        chk("wr_dready_after", dready, 1);
        chk("wr_ddone_pulse", ddone, 0);
        chk("wr_mvalid_run", last_run, 20);
        svalid = 1'b0; mrdata = 1'b0;

        // Read, slave answers 3 cycles after the address phase.
        s = done_cnt;
        do_req(1'b0, 12'h001, 8'h00, resp_t'{1'b0, 8'h96, 1'b0});
        wait_addr_end();
        slave_send(8'h96, 3, -1, 0);
        wait_done(s, lat);
        chk("rd_latency", lat, 24);
        chk("rd_addr_run", last_run, 12);

        // Read with a two-cycle svalid gap between bits 3 and 4.
        s = done_cnt;
        do_req(1'b0, 12'h800, 8'h00, resp_t'{1'b0, 8'hF0, 1'b0});
        wait_addr_end();
        slave_send(8'hF0, 3, 3, 2);
        wait_done(s, lat);
        chk("gap_latency", lat, 26);

        // sready held low for 10 cycles, then dropped again mid-transfer.
        sready = 1'b0;
        s = done_cnt;
        do_req(1'b1, 12'h3C5, 8'hA7, resp_t'{1'b1, 8'h00, 1'b0});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_mvalid", mvalid, 0);
            chk("stall_dready", dready, 0);
        end
        sready = 1'b1;
        @(negedge clk);
        chk("stall_addr_start", mvalid, 1);
        sready = 1'b0;
        wait_done(s, lat);
        chk("stall_latency", lat, 30);
        sready = 1'b1;

        // Reset during WDATA bit 4.
        s = done_cnt;
        do_req(1'b1, 12'h5A3, 8'hC3, resp_t'{1'b1, 8'h00, 1'b0});
        repeat (17) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        bit_q.delete();
        resp_q.delete();
        @(negedge clk);
        chk("rst_mid_mvalid", mvalid, 0);
        chk("rst_mid_dready", dready, 1);
        chk("rst_mid_ddone", ddone, 0);
        chk("rst_mid_drdata", drdata, 0);
        repeat (25) @(negedge clk);
        chk("rst_mid_no_done", done_cnt, s);

        // New request after reset completes normally.
        s = done_cnt;
        do_req(1'b0, 12'h7FF, 8'h00, resp_t'{1'b0, 8'h5A, 1'b0});
        wait_addr_end();
        slave_send(8'h5A, 0, -1, 0);
        wait_done(s, lat);
        chk("post_rst_latency", lat, 21);

`ifdef MPORT_TIMEOUT_EN
        // svalid never arrives: watchdog fires 64 cycles after entering RDATA.
        s = done_cnt;
        do_req(1'b0, 12'h123, 8'h00, resp_t'{1'b0, 8'h00, 1'b1});
        wait_addr_end();
        wait_done(s, lat);
        chk("to_latency", lat, 13 + 64);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", resp_q.size() + bit_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
